modexp_ctrl: RTL

//  Sequencer for the RSA modn reducer: computes result = base^exponent mod modulus by

---
 rtl/modexp_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: right-to-left square-and-multiply sequencer for base^exponent mod modulus on a shared modn unit (start/base/exponent/modulus in, busy/done/result/error out, mod_x/mod_y/mod_enable/mod_reset/mod_ready/mod_result handshake)
module modexp_ctrl #(
  parameter int EXP_W = 8,
  parameter int MAX_WAIT = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       base,
  input  logic [EXP_W-1:0] exponent,
  input  logic [7:0]       modulus,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic             error,
  output logic [15:0]      mod_x,
  output logic [7:0]       mod_y,
  output logic             mod_enable,
  output logic             mod_reset,
  input  logic             mod_ready,
  input  logic [7:0]       mod_result
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [3:0] {IDLE, CHK, RED_B, LOOP, MUL_A, SQR, FIN, OP_RST, OP_RUN} state_t;
  state_t state, state_n, ret, ret_n;
  logic [7:0] b, b_n, n, n_n, acc, acc_n, result_n;
  logic [EXP_W-1:0] e, e_n;
  logic [15:0] x, x_n;
  logic to_b, to_b_n, busy_n, error_n;
  logic [CW-1:0] cnt, cnt_n;
  assign done = state == FIN;
  assign mod_enable = state == OP_RUN;
  assign mod_reset = state == OP_RST;
  assign mod_x = x;
  assign mod_y = n;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ret <= IDLE;
      b <= '0;
      n <= '0;
      acc <= '0;
      e <= '0;
      x <= '0;
      to_b <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      result <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      b <= b_n;
      n <= n_n;
      acc <= acc_n;
      e <= e_n;
      x <= x_n;
      to_b <= to_b_n;
      cnt <= cnt_n;
      busy <= busy_n;
      result <= result_n;
      error <= error_n;
    end
  always_comb begin
    state_n = state;
    ret_n = ret;
    b_n = b;
    n_n = n;
    acc_n = acc;
    e_n = e;
    x_n = x;
    to_b_n = to_b;
    cnt_n = cnt;
    busy_n = busy;
    result_n = result;
    error_n = error;
    case (state)
      IDLE: if (start) begin
        b_n = base;
        e_n = exponent;
        n_n = modulus;
        busy_n = 1'b1;
        result_n = '0;
        error_n = 1'b0;
        state_n = CHK;
      end
      CHK: if (n == '0) begin
        error_n = 1'b1;
        result_n = '0;
        state_n = FIN;
      end else begin
        acc_n = (n == 8'd1) ? 8'd0 : 8'd1;
        state_n = RED_B;
      end
      RED_B: begin
        x_n = {8'h0, b};
        to_b_n = 1'b1;
        ret_n = LOOP;
        cnt_n = '0;
        state_n = OP_RST;
      end
      LOOP: begin
        result_n = (e == '0) ? acc : result;
        state_n = (e == '0) ? FIN : (e[0] ? MUL_A : SQR);
      end
      MUL_A: begin
        x_n = 16'(acc) * 16'(b);
        to_b_n = 1'b0;
        ret_n = SQR;
        cnt_n = '0;
        state_n = OP_RST;
      end
      SQR: begin
        e_n = e >> 1;
        state_n = LOOP;
        if (e_n != '0) begin
          x_n = 16'(b) * 16'(b);
          to_b_n = 1'b1;
          ret_n = LOOP;
          cnt_n = '0;
          state_n = OP_RST;
        end
      end
      OP_RST: state_n = OP_RUN;
      OP_RUN: if (mod_ready) begin
        b_n = to_b ? mod_result : b;
        acc_n = to_b ? acc : mod_result;
        state_n = ret;
      end else if (cnt == CW'(MAX_WAIT - 1)) begin
        error_n = 1'b1;
        result_n = '0;
        state_n = FIN;
      end else cnt_n = cnt + 1'b1;
      FIN: begin
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
